// File: rtl/weight_buffer_ctrl.sv
// Weight buffer sequencer: streams a fill burst into the buffer, then reads nb_taps
// consecutive words back and strobes the per-tap weight registers one cycle later.
module weight_buffer_ctrl #(
  parameter int nb_taps           = 5,
  parameter int buffer_depth      = 72,
  parameter int buffer_addr_width = $clog2(buffer_depth)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [buffer_addr_width:0]   cfg_fill_words,
  input  logic [buffer_addr_width-1:0] cfg_wr_base,
  input  logic [buffer_addr_width-1:0] cfg_rd_base,
  input  logic [3:0]                   cfg_n_ap,
  input  logic                         fill_valid,
  output logic                         fill_ready,
  input  logic                         load_hold,
  output logic                         buffer_wEn,
  output logic [buffer_addr_width-1:0] wAddr,
  output logic                         buffer_rEn,
  output logic [buffer_addr_width-1:0] rAddr,
  output logic [nb_taps-1:0]           weight_load_en,
  output logic [3:0]                   n_ap,
  output logic                         busy,
  output logic                         done
);

  localparam int tap_width = (nb_taps > 1) ? $clog2(nb_taps) : 1;
  localparam logic [buffer_addr_width:0]   depth_words = (buffer_addr_width+1)'(buffer_depth);
  localparam logic [buffer_addr_width:0]   one_cnt     = (buffer_addr_width+1)'(1);
  localparam logic [buffer_addr_width-1:0] last_addr   = buffer_addr_width'(buffer_depth - 1);
  localparam logic [buffer_addr_width-1:0] one_addr    = buffer_addr_width'(1);
  localparam logic [tap_width-1:0]         last_tap    = tap_width'(nb_taps - 1);
  localparam logic [tap_width-1:0]         one_tap     = tap_width'(1);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, LOAD = 2'd2, FLUSH = 2'd3} state_t;

  state_t                       state_r, state_s;
  logic [buffer_addr_width:0]   fill_cnt_r, wr_cnt_r, fill_clamp_s;
  logic [buffer_addr_width-1:0] wptr_r, rptr_r;
  logic [tap_width-1:0]         tap_r;
  logic [3:0]                   n_ap_r;
  logic [nb_taps-1:0]           wle_r;
  logic                         done_r;
  logic                         fill_ready_s, rd_issue_s, busy_s;
  logic                         fill_hs_s, last_wr_s, last_rd_s;

  function automatic logic [buffer_addr_width-1:0] wrap_inc(input logic [buffer_addr_width-1:0] ptr);
    if (ptr == last_addr) wrap_inc = {buffer_addr_width{1'b0}};
    else                  wrap_inc = ptr + one_addr;
  endfunction

  function automatic logic [nb_taps-1:0] tap_onehot(input logic [tap_width-1:0] idx);
    for (int k = 0; k < nb_taps; k++) begin
      if (idx == tap_width'(k)) tap_onehot[k] = 1'b1;
      else                      tap_onehot[k] = 1'b0;
    end
  endfunction

  assign fill_clamp_s = (cfg_fill_words > depth_words) ? depth_words : cfg_fill_words;
  assign fill_hs_s    = fill_ready_s & fill_valid;
  assign last_wr_s    = fill_hs_s & ((wr_cnt_r + one_cnt) == fill_cnt_r);
  assign last_rd_s    = rd_issue_s & (tap_r == last_tap);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = (fill_clamp_s != {(buffer_addr_width+1){1'b0}}) ? FILL : LOAD;
        else       state_s = IDLE;
      end
      FILL: begin
        if (last_wr_s) state_s = LOAD;
        else           state_s = FILL;
      end
      LOAD: begin
        if (last_rd_s) state_s = FLUSH;
        else           state_s = LOAD;
      end
      FLUSH:   state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State-decoded handshake and enable outputs
  always_comb begin
    fill_ready_s = 1'b0;
    rd_issue_s   = 1'b0;
    busy_s       = 1'b0;
    case (state_r)
      FILL: begin
        fill_ready_s = 1'b1;
        busy_s       = 1'b1;
      end
      LOAD: begin
        rd_issue_s = ~load_hold;
        busy_s     = 1'b1;
      end
      FLUSH:   busy_s = 1'b1;
      default: busy_s = 1'b0;
    endcase
  end

  // Command latch, pointers, counters and registered strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_cnt_r <= {(buffer_addr_width+1){1'b0}};
      wr_cnt_r   <= {(buffer_addr_width+1){1'b0}};
      wptr_r     <= {buffer_addr_width{1'b0}};
      rptr_r     <= {buffer_addr_width{1'b0}};
      tap_r      <= {tap_width{1'b0}};
      n_ap_r     <= 4'd0;
      wle_r      <= {nb_taps{1'b0}};
      done_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            fill_cnt_r <= fill_clamp_s;
            wr_cnt_r   <= {(buffer_addr_width+1){1'b0}};
            wptr_r     <= cfg_wr_base;
            rptr_r     <= cfg_rd_base;
            tap_r      <= {tap_width{1'b0}};
            n_ap_r     <= cfg_n_ap;
          end
        end
        FILL: begin
          if (fill_hs_s) begin
            wptr_r   <= wrap_inc(wptr_r);
            wr_cnt_r <= wr_cnt_r + one_cnt;
          end
        end
        LOAD: begin
          if (rd_issue_s) begin
            rptr_r <= wrap_inc(rptr_r);
            tap_r  <= tap_r + one_tap;
          end
        end
        default: tap_r <= tap_r;
      endcase
      // Strobe lands one cycle after its read to match the buffer read latency
      wle_r  <= rd_issue_s ? tap_onehot(tap_r) : {nb_taps{1'b0}};
      done_r <= last_rd_s;
    end
  end

  assign fill_ready     = fill_ready_s;
  assign buffer_wEn     = fill_hs_s;
  assign wAddr          = wptr_r;
  assign buffer_rEn     = rd_issue_s;
  assign rAddr          = rptr_r;
  assign weight_load_en = wle_r;
  assign n_ap           = n_ap_r;
  assign busy           = busy_s;
  assign done           = done_r;

endmodule

// File: doc/weight_buffer_ctrl.md
Name: weight_buffer_ctrl

Overview:
Sequencer for the weight buffer. Each command runs two phases:
- Fill: streams weight words from the upstream fill interface into the buffer banks.
- Load: reads nb_taps consecutive words back out and strobes the per-tap weight registers.

It drives the buffer's wAddr/rAddr/buffer_wEn/buffer_rEn/weight_load_en/n_ap pins; weight data itself bypasses this block.

Parameters:
- nb_taps, 5, number of weight taps per PE column; width of weight_load_en.
- buffer_depth, 72, words per buffer bank.
- buffer_addr_width, clogb2(buffer_depth) (=7), address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  command pulse; sampled only in IDLE.
- cfg_fill_words  in  buffer_addr_width+1  words to write in fill phase; 0 = skip fill.
- cfg_wr_base  in  buffer_addr_width  first write address.
- cfg_rd_base  in  buffer_addr_width  address of tap 0 for load phase.
- cfg_n_ap  in  4  precision config forwarded to buffer.
- fill_valid  in  1  upstream word valid.
- fill_ready  out  1  controller accepts word.
- load_hold  in  1  PE array stall; suppresses new reads.
- buffer_wEn  out  1  buffer write enable.
- wAddr  out  buffer_addr_width  buffer write address.
- buffer_rEn  out  1  buffer read enable.
- rAddr  out  buffer_addr_width  buffer read address.
- weight_load_en  out  nb_taps  one-hot tap register load strobe.
- n_ap  out  4  registered copy of cfg_n_ap.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Clock/reset: one clock; reset is asynchronous and active-low; ports named clk and rst_n.
- Reset values: state=IDLE; all outputs 0, including n_ap, wAddr, rAddr and pointers/counters. rst_n assertion mid-operation aborts immediately; no pending strobe survives.
- States: IDLE, FILL, LOAD, FLUSH.
- IDLE, start=1 (cycle 0):
  - Latch cfg_* on this edge; n_ap updates at cycle 1.
  - Clamp fill count to buffer_depth if cfg_fill_words > buffer_depth.
  - wptr<=cfg_wr_base, rptr<=cfg_rd_base, tap<=0.
  - Next state FILL if count>0, else LOAD.
- start while busy: ignored, no side effects.
- FILL:
  - fill_ready=1 (combinational from state).
  - buffer_wEn = fill_valid & fill_ready; wAddr = wptr.
  - On each handshake: wptr increments, wrapping buffer_depth-1 -> 0; write counter increments.
  - On the handshake that writes the final word, next state LOAD.
  - fill_valid=0 cycles stall without penalty; load_hold has no effect in FILL.
- LOAD:
  - buffer_rEn = ~load_hold (combinational); rAddr = rptr.
  - On each issued read: rptr increments with the same wrap rule; tap increments.
  - The read issuing tap nb_taps-1 moves state to FLUSH.
  - load_hold=1: no read, rptr/tap frozen.
- weight_load_en (registered, 1-cycle buffer read latency):
  - Bit k is set in the cycle after the read of tap k issued; otherwise 0.
  - Exactly nb_taps strobes per command, in order 0..nb_taps-1.
  - Strobes are never suppressed by load_hold.
- FLUSH (one cycle): weight_load_en[nb_taps-1]=1 and done=1; next state IDLE.
- busy/back-to-back: busy is 0 in the cycle after FLUSH, and a start in that cycle is accepted (back-to-back commands).
- Address wrap: rptr and wptr wrap buffer_depth-1 -> 0. Filling with wrap over the addresses being loaded is legal; the controller performs no overlap check.
- Minimum latency, cfg_fill_words=0 and no hold: start at cycle 0; reads at cycles 1..nb_taps; done at cycle nb_taps+1.

Test Plan:
- Reset mid-LOAD: deassert rst_n after 2 reads -> all outputs 0 asynchronously; after release, state IDLE; a new start runs a full sequence.
- Basic fill+load: cfg_fill_words=5, cfg_wr_base=10, cfg_rd_base=10, fill_valid always 1 ->
  - wEn cycles 1-5 with wAddr 10..14.
  - rEn cycles 6-10 with rAddr 10..14.
  - weight_load_en 00001..10000 in cycles 7-11; done at cycle 11.
- Wrap: cfg_wr_base=70, cfg_fill_words=4 -> wAddr 70,71,0,1. cfg_rd_base=69 -> rAddr 69,70,71,0,1.
- Stalls: fill_valid toggling 1,0,1,0..., then load_hold high for 3 cycles after the 2nd read -> write addresses contiguous with no skipped words; rAddr sequence unchanged; exactly 5 one-hot strobes; done is delayed by 3 cycles.
- Clamp and ignore:
  - cfg_fill_words=100 -> exactly 72 writes.
  - start pulsed during FILL -> no effect; n_ap stays at the first latched value.
- Skip fill and back-to-back: cfg_fill_words=0 -> no wEn; done at cycle 6. start in cycle 7 is accepted and busy re-asserts in cycle 8.
